// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light blocks.
//   - 3-bit controller state encodings (one code is left unused)
//   - 2-bit grant encodings (NONE / SIDE / PED)
//   - lamp bit positions within the 8-bit lamp vector
//   - interval timer width
//   - lamp_decode(): steady lamp pattern shown in each state
package tl_pkg;

    localparam int TIMER_W = 30;

    typedef enum logic [2:0] {
        ST_ALLRED      = 3'd0,
        ST_MAIN_GREEN  = 3'd1,
        ST_MAIN_YELLOW = 3'd2,
        ST_SIDE_GREEN  = 3'd3,
        ST_SIDE_YELLOW = 3'd4,
        ST_PED_WALK    = 3'd5,
        ST_PED_CLEAR   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_SIDE = 2'd1,
        GRANT_PED  = 2'd2
    } grant_t;

    localparam int LAMP_W           = 8;
    localparam int LAMP_MAIN_GREEN  = 7;
    localparam int LAMP_MAIN_YELLOW = 6;
    localparam int LAMP_MAIN_RED    = 5;
    localparam int LAMP_SIDE_GREEN  = 4;
    localparam int LAMP_SIDE_YELLOW = 3;
    localparam int LAMP_SIDE_RED    = 2;
    localparam int LAMP_PED_GREEN   = 1;
    localparam int LAMP_PED_RED     = 0;

    // Any encoding that is not a known state shows the all-red pattern.
    function automatic logic [LAMP_W-1:0] lamp_decode(state_t st);
        logic [LAMP_W-1:0] lamps;
        lamps = '0;
        case (st)
            ST_MAIN_GREEN: begin
                lamps[LAMP_MAIN_GREEN] = 1'b1;
                lamps[LAMP_SIDE_RED]   = 1'b1;
                lamps[LAMP_PED_RED]    = 1'b1;
            end
            ST_MAIN_YELLOW: begin
                lamps[LAMP_MAIN_YELLOW] = 1'b1;
                lamps[LAMP_SIDE_RED]    = 1'b1;
                lamps[LAMP_PED_RED]     = 1'b1;
            end
            ST_SIDE_GREEN: begin
                lamps[LAMP_SIDE_GREEN] = 1'b1;
                lamps[LAMP_MAIN_RED]   = 1'b1;
                lamps[LAMP_PED_RED]    = 1'b1;
            end
            ST_SIDE_YELLOW: begin
                lamps[LAMP_SIDE_YELLOW] = 1'b1;
                lamps[LAMP_MAIN_RED]    = 1'b1;
                lamps[LAMP_PED_RED]     = 1'b1;
            end
            ST_PED_WALK: begin
                lamps[LAMP_PED_GREEN] = 1'b1;
                lamps[LAMP_MAIN_RED]  = 1'b1;
                lamps[LAMP_SIDE_RED]  = 1'b1;
            end
            default: begin
                lamps[LAMP_MAIN_RED] = 1'b1;
                lamps[LAMP_SIDE_RED] = 1'b1;
                lamps[LAMP_PED_RED]  = 1'b1;
            end
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/tl_interval_timer.sv
// Saturating down-counter used to time traffic-light intervals.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (loads RESET_VALUE)
//   load       in   load load_value this cycle (takes priority over count)
//   load_value in   TIMER_W-bit value to load
//   count      in   decrement enable; the counter stops at zero
//   zero       out  counter currently equals zero
module tl_interval_timer
    import tl_pkg::*;
#(
    parameter logic [TIMER_W-1:0] RESET_VALUE = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               count,
    output logic               zero
);

    logic [TIMER_W-1:0] value_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= RESET_VALUE;
        end else if (load) begin
            value_q <= load_value;
        end else if (count && (value_q != '0)) begin
            value_q <= value_q - TIMER_W'(1);
        end
    end

    assign zero = (value_q == '0);

endmodule

// File: rtl/crossing_scheduler.sv
// Main road / side road / pedestrian crossing controller. Main road holds
// green; once its minimum green has elapsed the side-road sensor and the
// latched pedestrian request are served round-robin, with yellow and
// all-red clearance between every change of right of way.
// Ports:
//   pin3_clk_16mhz                      in   system clock
//   rst_n                               in   asynchronous active-low reset
//   side_req                            in   side-road car sensor (synchronous level)
//   ped_btn                             in   raw asynchronous pedestrian button
//   main_green/main_yellow/main_red     out  main road lamps
//   side_green/side_yellow/side_red     out  side road lamps
//   ped_green/ped_red                   out  pedestrian lamps
//   ped_wait                            out  pedestrian request is latched
// Build option: define CROSSING_PED_FLASH_EN to flash ped_green during
// pedestrian clearance instead of showing a steady ped_red.
module crossing_scheduler
    import tl_pkg::*;
#(
    parameter int TIMER_SCALE = 16000000,
    parameter int MAIN_MIN_S  = 10,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 2,
    parameter int SIDE_S      = 8,
    parameter int WALK_S      = 6,
    parameter int CLEAR_S     = 4
) (
    input  logic pin3_clk_16mhz,
    input  logic rst_n,
    input  logic side_req,
    input  logic ped_btn,
    output logic main_green,
    output logic main_yellow,
    output logic main_red,
    output logic side_green,
    output logic side_yellow,
    output logic side_red,
    output logic ped_green,
    output logic ped_red,
    output logic ped_wait
);

    localparam longint SCALE       = longint'(TIMER_SCALE);
    localparam longint TIMER_LIMIT = longint'(1) << TIMER_W;

    function automatic bit duration_ok(longint seconds);
        return (seconds >= 1) && (SCALE >= 1) && (seconds * SCALE < TIMER_LIMIT);
    endfunction

    if (!duration_ok(MAIN_MIN_S) || !duration_ok(YELLOW_S) || !duration_ok(ALLRED_S) ||
        !duration_ok(SIDE_S) || !duration_ok(WALK_S) || !duration_ok(CLEAR_S)) begin : g_duration_check
        $error("crossing_scheduler: an interval does not fit the %0d-bit timer", TIMER_W);
    end

    // Loading N*SCALE-1 makes a state last exactly N*SCALE cycles, because
    // the exit decision is taken on the cycle the counter reads zero.
    localparam logic [TIMER_W-1:0] LOAD_ALLRED = TIMER_W'(longint'(ALLRED_S)   * SCALE - 1);
    localparam logic [TIMER_W-1:0] LOAD_MAIN   = TIMER_W'(longint'(MAIN_MIN_S) * SCALE - 1);
    localparam logic [TIMER_W-1:0] LOAD_YELLOW = TIMER_W'(longint'(YELLOW_S)   * SCALE - 1);
    localparam logic [TIMER_W-1:0] LOAD_SIDE   = TIMER_W'(longint'(SIDE_S)     * SCALE - 1);
    localparam logic [TIMER_W-1:0] LOAD_WALK   = TIMER_W'(longint'(WALK_S)     * SCALE - 1);
    localparam logic [TIMER_W-1:0] LOAD_CLEAR  = TIMER_W'(longint'(CLEAR_S)    * SCALE - 1);

    localparam logic [LAMP_W-1:0] LAMP_RESET = lamp_decode(ST_ALLRED);

    state_t             state_q, state_d;
    grant_t             grant_q, grant_d;
    grant_t             rr_q, rr_d;
    logic               ped_latch_q, ped_latch_d;
    logic [1:0]         ped_sync_q;
    logic               ped_prev_q;
    logic               ped_edge;
    logic [LAMP_W-1:0]  lamp_q, lamp_d;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_value;
    logic               timer_zero;

    tl_interval_timer #(
        .RESET_VALUE (LOAD_ALLRED)
    ) u_timer (
        .clk        (pin3_clk_16mhz),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_load_value),
        .count      (1'b1),
        .zero       (timer_zero)
    );

    assign ped_edge = ped_sync_q[1] & ~ped_prev_q;

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        rr_d             = rr_q;
        timer_load       = 1'b0;
        timer_load_value = LOAD_ALLRED;

        case (state_q)
            ST_ALLRED: begin
                if (timer_zero) begin
                    case (grant_q)
                        GRANT_SIDE: state_d = ST_SIDE_GREEN;
                        GRANT_PED:  state_d = ST_PED_WALK;
                        default:    state_d = ST_MAIN_GREEN;
                    endcase
                end
            end
            ST_MAIN_GREEN: begin
                // The granted requester is whichever wins; the pointer then
                // always favours the one that lost or was absent.
                if (timer_zero && (side_req || ped_latch_q)) begin
                    state_d = ST_MAIN_YELLOW;
                    if (side_req && ped_latch_q) begin
                        grant_d = rr_q;
                    end else if (side_req) begin
                        grant_d = GRANT_SIDE;
                    end else begin
                        grant_d = GRANT_PED;
                    end
                    if (grant_d == GRANT_SIDE) begin
                        rr_d = GRANT_PED;
                    end else begin
                        rr_d = GRANT_SIDE;
                    end
                end
            end
            ST_MAIN_YELLOW: if (timer_zero) state_d = ST_ALLRED;
            ST_SIDE_GREEN:  if (timer_zero) state_d = ST_SIDE_YELLOW;
            ST_SIDE_YELLOW: begin
                if (timer_zero) begin
                    state_d = ST_ALLRED;
                    grant_d = GRANT_NONE;
                end
            end
            ST_PED_WALK:    if (timer_zero) state_d = ST_PED_CLEAR;
            ST_PED_CLEAR: begin
                if (timer_zero) begin
                    state_d = ST_ALLRED;
                    grant_d = GRANT_NONE;
                end
            end
            default: begin
                state_d = ST_ALLRED;
                grant_d = GRANT_NONE;
            end
        endcase

        if (state_d != state_q) begin
            timer_load = 1'b1;
            case (state_d)
                ST_MAIN_GREEN:  timer_load_value = LOAD_MAIN;
                ST_MAIN_YELLOW: timer_load_value = LOAD_YELLOW;
                ST_SIDE_GREEN:  timer_load_value = LOAD_SIDE;
                ST_SIDE_YELLOW: timer_load_value = LOAD_YELLOW;
                ST_PED_WALK:    timer_load_value = LOAD_WALK;
                ST_PED_CLEAR:   timer_load_value = LOAD_CLEAR;
                default:        timer_load_value = LOAD_ALLRED;
            endcase
        end

        // Walking pedestrians are being served, so presses during the walk
        // (and the entry cycle itself) are dropped rather than queued.
        if ((state_q == ST_PED_WALK) || (state_d == ST_PED_WALK)) begin
            ped_latch_d = 1'b0;
        end else begin
            ped_latch_d = ped_latch_q | ped_edge;
        end
    end

`ifdef CROSSING_PED_FLASH_EN
    localparam int HALF_PERIOD = (TIMER_SCALE / 2 > 0) ? (TIMER_SCALE / 2) : 1;
    localparam logic [TIMER_W-1:0] FLASH_RELOAD = TIMER_W'(HALF_PERIOD - 1);

    logic               flash_q, flash_d;
    logic [TIMER_W-1:0] flash_cnt_q, flash_cnt_d;

    // Flash phase restarts "on" every time clearance is entered.
    always_comb begin
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q;
        if (state_d == ST_PED_CLEAR) begin
            if (state_q != ST_PED_CLEAR) begin
                flash_d     = 1'b1;
                flash_cnt_d = FLASH_RELOAD;
            end else if (flash_cnt_q == '0) begin
                flash_d     = ~flash_q;
                flash_cnt_d = FLASH_RELOAD;
            end else begin
                flash_cnt_d = flash_cnt_q - TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge pin3_clk_16mhz or negedge rst_n) begin
        if (!rst_n) begin
            flash_q     <= 1'b0;
            flash_cnt_q <= '0;
        end else begin
            flash_q     <= flash_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    always_comb begin
        lamp_d = lamp_decode(state_d);
        if (state_d == ST_PED_CLEAR) begin
            lamp_d[LAMP_PED_GREEN] = flash_d;
            lamp_d[LAMP_PED_RED]   = 1'b0;
        end
    end
`else
    always_comb begin
        lamp_d = lamp_decode(state_d);
    end
`endif

    // Lamps are registered from the next-state decode so they switch on the
    // same edge as the state register and never glitch on the pins.
    always_ff @(posedge pin3_clk_16mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ALLRED;
            grant_q     <= GRANT_NONE;
            rr_q        <= GRANT_SIDE;
            ped_latch_q <= 1'b0;
            ped_sync_q  <= 2'b00;
            ped_prev_q  <= 1'b0;
            lamp_q      <= LAMP_RESET;
            ped_wait    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            ped_latch_q <= ped_latch_d;
            ped_sync_q  <= {ped_sync_q[0], ped_btn};
            ped_prev_q  <= ped_sync_q[1];
            lamp_q      <= lamp_d;
            ped_wait    <= ped_latch_d;
        end
    end

    assign main_green  = lamp_q[LAMP_MAIN_GREEN];
    assign main_yellow = lamp_q[LAMP_MAIN_YELLOW];
    assign main_red    = lamp_q[LAMP_MAIN_RED];
    assign side_green  = lamp_q[LAMP_SIDE_GREEN];
    assign side_yellow = lamp_q[LAMP_SIDE_YELLOW];
    assign side_red    = lamp_q[LAMP_SIDE_RED];
    assign ped_green   = lamp_q[LAMP_PED_GREEN];
    assign ped_red     = lamp_q[LAMP_PED_RED];

endmodule
